// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences FETCH/DECODE/EXEC/MEM/WB over a shared datapath,
// counts retired instructions and traps on illegal encodings or memory timeouts.
module multicycle_controller #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             z,
  input  logic             mem_ready,
  output logic             pc_wr,
  output logic             ir_wr,
  output logic             iord,
  output logic             mem_rd,
  output logic             mem_wr,
  output logic             reg_wr,
  output logic [1:0]       reg_dst,
  output logic [1:0]       mem_to_reg,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_control,
  output logic             ext_op,
  output logic [1:0]       pc_src,
  output logic             instr_done,
  output logic [CNT_W-1:0] retire_count,
  output logic             error
);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_LUI  = 6'b001111;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  localparam logic [5:0] FN_JR  = 6'b001000;
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_NOR = 6'b100111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_OR  = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b011;
  localparam logic [2:0] ALU_AND = 3'b100;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_BRANCH, S_MEMRD, S_MEMWR, S_WB, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [CNT_W-1:0]  retire_q;
  logic              r_alu_legal;
  logic [2:0]        r_alu_op;
  logic              timeout;

  always_comb begin
    r_alu_legal = 1'b1;
    r_alu_op    = ALU_ADD;
    unique case (funct)
      FN_ADD:  r_alu_op = ALU_ADD;
      FN_SUB:  r_alu_op = ALU_SUB;
      FN_AND:  r_alu_op = ALU_AND;
      FN_OR:   r_alu_op = ALU_OR;
      FN_NOR:  r_alu_op = ALU_NOR;
      default: r_alu_legal = 1'b0;
    endcase
  end

  // The stall that would make the count reach MEM_TIMEOUT traps instead of waiting further.
  assign timeout = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));

  always_comb begin
    state_d     = state_q;
    wait_d      = '0;
    pc_wr       = 1'b0;
    ir_wr       = 1'b0;
    iord        = 1'b0;
    mem_rd      = 1'b0;
    mem_wr      = 1'b0;
    reg_wr      = 1'b0;
    reg_dst     = 2'b00;
    mem_to_reg  = 2'b00;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    alu_control = ALU_ADD;
    ext_op      = 1'b0;
    pc_src      = 2'b00;
    instr_done  = 1'b0;
    unique case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'b01;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        alu_src_b = 2'b11;
        ext_op    = 1'b1;
        unique case (opcode)
          OP_R: begin
            if (funct == FN_JR) begin
              pc_wr      = 1'b1;
              pc_src     = 2'b11;
              instr_done = 1'b1;
              state_d    = S_FETCH;
            end else if (r_alu_legal) begin
              state_d = S_EXEC;
            end else begin
              state_d = S_ERROR;
            end
          end
          OP_J, OP_JAL: begin
            pc_wr      = 1'b1;
            pc_src     = 2'b10;
            instr_done = 1'b1;
            state_d    = S_FETCH;
            if (opcode == OP_JAL) begin
              reg_wr     = 1'b1;
              reg_dst    = 2'b10;
              mem_to_reg = 2'b10;
            end
          end
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: state_d = S_EXEC;
          default: state_d = S_ERROR;
        endcase
      end
      S_BRANCH: begin
        alu_src_a   = 1'b1;
        alu_control = ALU_SUB;
        instr_done  = 1'b1;
        state_d     = S_FETCH;
        if ((opcode == OP_BEQ && z) || (opcode == OP_BNE && !z)) begin
          pc_wr  = 1'b1;
          pc_src = 2'b01;
        end
      end
      S_EXEC: begin
        state_d = S_WB;
        unique case (opcode)
          OP_R: begin
            alu_src_a   = 1'b1;
            alu_control = r_alu_op;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            alu_src_b = 2'b10;
            ext_op    = 1'b1;
            if (opcode == OP_LW) state_d = S_MEMRD;
            if (opcode == OP_SW) state_d = S_MEMWR;
          end
          OP_ANDI: begin
            alu_src_b   = 2'b10;
            alu_control = ALU_AND;
          end
          OP_ORI: begin
            alu_src_b   = 2'b10;
            alu_control = ALU_OR;
          end
          OP_LUI: ;
          default: state_d = S_ERROR;
        endcase
      end
      S_MEMRD, S_MEMWR: begin
        iord   = 1'b1;
        mem_rd = (state_q == S_MEMRD);
        mem_wr = (state_q == S_MEMWR);
        if (mem_ready) begin
          instr_done = (state_q == S_MEMWR);
          state_d    = (state_q == S_MEMWR) ? S_FETCH : S_WB;
        end else if (timeout) begin
          state_d = S_ERROR;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
        unique case (opcode)
          OP_R:    begin reg_dst = 2'b00; mem_to_reg = 2'b00; end
          OP_LW:   begin reg_dst = 2'b01; mem_to_reg = 2'b01; end
          OP_LUI:  begin reg_dst = 2'b01; mem_to_reg = 2'b11; end
          default: begin reg_dst = 2'b01; mem_to_reg = 2'b00; end
        endcase
      end
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wait_q   <= '0;
      retire_q <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      if (instr_done) retire_q <= retire_q + CNT_W'(1);
    end
  end

  assign retire_count = retire_q;
  assign error        = (state_q == S_ERROR);
endmodule
